// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the unified memory port arbiter.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              data_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        output data_req, data_we, data_addr, data_wdata,
        output mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data having priority.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
        logic   err;
    } ret_t;

    logic              guard_force;
    logic              fetch_acc;
    logic              data_acc;
    logic              data_misal;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    ret_t              ret_q, ret_d;
    logic              fetch_rvalid_q, fetch_rvalid_d;
    logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
    logic              data_rvalid_q, data_rvalid_d;
    logic              data_err_q, data_err_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    if (MAX_DATA_STREAK < 1) begin : g_cfg_check
        $error("MAX_DATA_STREAK must be at least 1");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_DATA_STREAK + 1);

    logic [CNT_W-1:0] streak_q, streak_d;

    // Saturates so a flushed cycle at the limit cannot wrap the count.
    always_comb begin
        streak_d = streak_q;
        if (!bus.fetch_req || fetch_acc) begin
            streak_d = '0;
        end else if (data_acc && (streak_q != CNT_W'(MAX_DATA_STREAK))) begin
            streak_d = streak_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign guard_force = (streak_q == CNT_W'(MAX_DATA_STREAK)) && bus.fetch_req && !bus.fetch_flush;
`else
    assign guard_force = 1'b0;
`endif

    assign data_acc   = rst_n && bus.data_req && !guard_force;
    assign fetch_acc  = rst_n && bus.fetch_req && !bus.fetch_flush && (!bus.data_req || guard_force);
    assign data_misal = |bus.data_addr[1:0];

    assign bus.data_gnt  = data_acc;
    assign bus.fetch_gnt = fetch_acc;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        ret_d       = '0;
        if (fetch_acc) begin
            mem_addr_d    = bus.fetch_addr & ~ADDR_W'(3);
            ret_d.valid   = 1'b1;
            ret_d.owner   = OWN_FETCH;
            ret_d.is_read = 1'b1;
        end else if (data_acc) begin
            ret_d.valid   = 1'b1;
            ret_d.owner   = OWN_DATA;
            ret_d.is_read = !bus.data_we;
            ret_d.err     = data_misal;
            // Misaligned accesses never reach the port, which also keeps byte+3 inside the array.
            if (!data_misal) begin
                mem_addr_d  = bus.data_addr;
                mem_we_d    = bus.data_we;
                mem_wdata_d = bus.data_wdata;
            end
        end
    end

    always_comb begin
        fetch_rvalid_d = ret_q.valid && (ret_q.owner == OWN_FETCH) && !bus.fetch_flush;
        fetch_rdata_d  = fetch_rdata_q;
        if (ret_q.valid && (ret_q.owner == OWN_FETCH)) begin
            fetch_rdata_d = bus.mem_rdata;
        end
        data_rvalid_d = ret_q.valid && (ret_q.owner == OWN_DATA) && (ret_q.is_read || ret_q.err);
        data_err_d    = ret_q.valid && (ret_q.owner == OWN_DATA) && ret_q.err;
        data_rdata_d  = data_rdata_q;
        if (data_rvalid_d) begin
            data_rdata_d = ret_q.err ? '0 : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            ret_q          <= '0;
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= '0;
            data_rvalid_q  <= 1'b0;
            data_err_q     <= 1'b0;
            data_rdata_q   <= '0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
            ret_q          <= ret_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            data_rvalid_q  <= data_rvalid_d;
            data_err_q     <= data_err_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.fetch_rvalid = fetch_rvalid_q;
    assign bus.fetch_rdata  = fetch_rdata_q;
    assign bus.data_rvalid  = data_rvalid_q;
    assign bus.data_err     = data_err_q;
    assign bus.data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases and a random
// phase scored against a per-access reference model and a byte-array memory.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int MAXS   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(MAXS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0] mem     [1024];
    logic [7:0] ref_mem [1024];
    int checks = 0;
    int errors = 0;

    // Expected effect of one accepted access: port activity one edge later, response two edges later.
    typedef struct {
        logic        fv;
        logic        dv;
        logic        derr;
        logic        we;
        logic        achk;
        logic [9:0]  addr;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t cur, prev;
    int   streak;
    logic obs_fg, obs_dg;

    typedef struct {
        logic        is_f;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        exp_we;
        logic        exp_fv;
        logic        exp_dv;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    always @(negedge clk) begin
        int idx;
        idx = int'(bus.mem_addr);
        if (idx <= 1020) begin
            if (bus.mem_we === 1'b1) begin
                for (int i = 0; i < 4; i++) mem[idx + i] = bus.mem_wdata[8*i +: 8];
            end
            bus.mem_rdata = {mem[idx + 3], mem[idx + 2], mem[idx + 1], mem[idx]};
        end
    end

    function automatic logic [31:0] init_word(int a);
        return 32'h1000_0000 | (32'(a) << 16) | 32'(a);
    endfunction

    function automatic logic [31:0] ref_word(logic [9:0] a);
        int b;
        b = int'(a);
        return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    endfunction

    task automatic ref_write(logic [9:0] a, logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = w[8*i +: 8];
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_flush = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_we     = 1'b0;
        bus.data_addr   = '0;
        bus.data_wdata  = '0;
    endtask

    // Called at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic cycle();
        exp_t nxt;
        logic force_f, eg_f, eg_d;
        #2;
        force_f = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        force_f = (streak == MAXS) && bus.fetch_req && !bus.fetch_flush;
`endif
        eg_d = bus.data_req && !force_f;
        eg_f = bus.fetch_req && !bus.fetch_flush && (!bus.data_req || force_f);
        obs_fg = bus.fetch_gnt;
        obs_dg = bus.data_gnt;
        chk("fetch_gnt", 32'(obs_fg), 32'(eg_f));
        chk("data_gnt", 32'(obs_dg), 32'(eg_d));

        nxt = '{default: '0};
        if (eg_f) begin
            nxt.fv    = 1'b1;
            nxt.achk  = 1'b1;
            nxt.addr  = {bus.fetch_addr[9:2], 2'b00};
            nxt.rdata = ref_word(nxt.addr);
        end else if (eg_d) begin
            if (bus.data_addr[1:0] != 2'b00) begin
                nxt.dv   = 1'b1;
                nxt.derr = 1'b1;
            end else begin
                nxt.achk = 1'b1;
                nxt.addr = bus.data_addr;
                if (bus.data_we) begin
                    nxt.we    = 1'b1;
                    nxt.wdata = bus.data_wdata;
                    ref_write(bus.data_addr, bus.data_wdata);
                end else begin
                    nxt.dv    = 1'b1;
                    nxt.rdata = ref_word(bus.data_addr);
                end
            end
        end
        prev = cur;
        if (bus.fetch_flush) prev.fv = 1'b0;
        cur = nxt;
        if (!bus.fetch_req || eg_f) streak = 0;
        else if (eg_d && streak < MAXS) streak++;

        @(posedge clk);
        #1;
        chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
        if (cur.achk) chk("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
        if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
        chk("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(prev.fv));
        if (prev.fv) chk("fetch_rdata", bus.fetch_rdata, prev.rdata);
        chk("data_rvalid", 32'(bus.data_rvalid), 32'(prev.dv));
        chk("data_err", 32'(bus.data_err), 32'(prev.derr));
        if (prev.dv) chk("data_rdata", bus.data_rdata, prev.rdata);
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            #2;
            chk("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
            chk("rst_data_gnt", 32'(bus.data_gnt), 32'd0);
            @(posedge clk);
            #1;
            chk("rst_fetch_rvalid", 32'(bus.fetch_rvalid), 32'd0);
            chk("rst_data_rvalid", 32'(bus.data_rvalid), 32'd0);
            chk("rst_data_err", 32'(bus.data_err), 32'd0);
            chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
            chk("rst_fetch_rdata", bus.fetch_rdata, 32'd0);
            chk("rst_data_rdata", bus.data_rdata, 32'd0);
        end
        rst_n  = 1'b1;
        cur    = '{default: '0};
        prev   = cur;
        streak = 0;
    endtask

    initial begin
        logic seen_we, seen_we2;
        logic exp_pat [10];

        for (int a = 0; a < 1024; a += 4) begin
            for (int i = 0; i < 4; i++) begin
                mem[a + i]     = init_word(a)[8*i +: 8];
                ref_mem[a + i] = mem[a + i];
            end
        end
        bus.mem_rdata = '0;

        vecs[0] = '{1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b0, 10'h010, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0000};
        vecs[3] = '{1'b1, 1'b0, 10'h006, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h1004_0004};
        vecs[4] = '{1'b0, 1'b0, 10'h013, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b1, 10'h022, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[6] = '{1'b0, 1'b0, 10'h3FC, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h13FC_03FC};
        vecs[7] = '{1'b0, 1'b0, 10'h3FE, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[8] = '{1'b0, 1'b0, 10'h020, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h1020_0020};

        // Reset with both requests held; the first accept afterwards must go to data.
        idle_inputs();
        bus.fetch_req = 1'b1;
        bus.data_req  = 1'b1;
        bus.data_addr = 10'h100;
        do_reset(3);
        cycle();
        chk("first_accept_data", 32'(obs_dg), 32'd1);
        chk("first_accept_not_fetch", 32'(obs_fg), 32'd0);
        bus.data_req = 1'b0;
        cycle();
        idle_inputs();
        cycle();
        cycle();

        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            if (vecs[i].is_f) begin
                bus.fetch_req  = 1'b1;
                bus.fetch_addr = vecs[i].addr;
            end else begin
                bus.data_req   = 1'b1;
                bus.data_we    = vecs[i].we;
                bus.data_addr  = vecs[i].addr;
                bus.data_wdata = vecs[i].wdata;
            end
            cycle();
            chk("vec_gnt", 32'(vecs[i].is_f ? obs_fg : obs_dg), 32'd1);
            seen_we = bus.mem_we;
            idle_inputs();
            cycle();
            chk("vec_mem_we", 32'(seen_we), 32'(vecs[i].exp_we));
            chk("vec_fetch_rvalid", 32'(bus.fetch_rvalid), 32'(vecs[i].exp_fv));
            chk("vec_data_rvalid", 32'(bus.data_rvalid), 32'(vecs[i].exp_dv));
            chk("vec_data_err", 32'(bus.data_err), 32'(vecs[i].exp_err));
            if (vecs[i].is_f) chk("vec_fetch_rdata", bus.fetch_rdata, vecs[i].exp_rdata);
            else if (vecs[i].exp_dv) chk("vec_data_rdata", bus.data_rdata, vecs[i].exp_rdata);
            cycle();
        end
        chk("misaligned_store_mem_untouched", {mem[10'h023], mem[10'h022], mem[10'h021], mem[10'h020]}, 32'h1020_0020);

        // Store then load on the next edge.
        idle_inputs();
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 10'h080; bus.data_wdata = 32'hCAFEF00D;
        cycle();
        seen_we = bus.mem_we;
        bus.data_we = 1'b0;
        cycle();
        seen_we2 = bus.mem_we;
        idle_inputs();
        cycle();
        chk("st_ld_we_first", 32'(seen_we), 32'd1);
        chk("st_ld_we_second", 32'(seen_we2), 32'd0);
        chk("st_ld_rvalid", 32'(bus.data_rvalid), 32'd1);
        chk("st_ld_rdata", bus.data_rdata, 32'hCAFEF00D);
        cycle();

        // Back-to-back fetches at 0x000, 0x004, 0x008.
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            if (k < 3) begin
                bus.fetch_req  = 1'b1;
                bus.fetch_addr = 10'(4 * k);
            end
            cycle();
            if (k >= 1 && k <= 3) begin
                chk("b2b_fetch_rvalid", 32'(bus.fetch_rvalid), 32'd1);
                chk("b2b_fetch_rdata", bus.fetch_rdata, init_word(4 * (k - 1)));
            end else if (k == 4) begin
                chk("b2b_fetch_tail", 32'(bus.fetch_rvalid), 32'd0);
            end
        end

        // Flush one edge after a fetch accept kills its response and blocks that cycle's grant.
        idle_inputs();
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'h00C;
        cycle();
        bus.fetch_flush = 1'b1;
        cycle();
        chk("flush_blocks_gnt", 32'(obs_fg), 32'd0);
        chk("flush_kills_rvalid", 32'(bus.fetch_rvalid), 32'd0);
        bus.fetch_flush = 1'b0;
        cycle();
        idle_inputs();
        cycle();
        chk("after_flush_rvalid", 32'(bus.fetch_rvalid), 32'd1);
        chk("after_flush_rdata", bus.fetch_rdata, init_word(12));
        cycle();

        // Both requesters held high for ten grants.
        for (int i = 0; i < 10; i++) exp_pat[i] = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_pat[4] = 1'b1;
        exp_pat[9] = 1'b1;
`endif
        bus.fetch_req = 1'b1; bus.fetch_addr = 10'h040;
        bus.data_req  = 1'b1; bus.data_addr  = 10'h100;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("guard_pattern_fetch", 32'(obs_fg), 32'(exp_pat[i]));
            chk("guard_pattern_data", 32'(obs_dg), 32'(!exp_pat[i]));
        end
        idle_inputs();
        cycle();
        cycle();

        // Random traffic; requests stay up with stable payload until granted.
        for (int n = 0; n < 400; n++) begin
            if (!bus.fetch_req && $urandom_range(0, 99) < 60) begin
                bus.fetch_req  = 1'b1;
                bus.fetch_addr = 10'($urandom_range(0, 1023));
            end
            if (!bus.data_req && $urandom_range(0, 99) < 55) begin
                bus.data_req   = 1'b1;
                bus.data_we    = 1'($urandom_range(0, 1));
                bus.data_wdata = $urandom;
                if ($urandom_range(0, 99) < 25) bus.data_addr = 10'($urandom_range(0, 1023));
                else bus.data_addr = 10'(4 * $urandom_range(0, 255));
            end
            bus.fetch_flush = ($urandom_range(0, 99) < 15);
            cycle();
            if (obs_fg) bus.fetch_req = 1'b0;
            if (obs_dg) bus.data_req = 1'b0;
        end
        idle_inputs();
        cycle();
        cycle();

        // Reset while a load is in flight: no response may appear.
        bus.data_req = 1'b1; bus.data_addr = 10'h040;
        cycle();
        idle_inputs();
        bus.fetch_req = 1'b1;
        do_reset(2);
        idle_inputs();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported, byte-addressable 1 KiB unified memory of the pipelined processor. It shares the memory port between the instruction-fetch stage and the load/store (MEM) stage. It registers the selected access onto the memory port, returns 32-bit little-endian read data with fixed latency, and rejects misaligned data accesses. It also supports fetch flush on branch redirect.

## Interface
- ADDR_W, 10, byte address width (memory depth 2^ADDR_W bytes)
- DATA_W, 32, word width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (starvation guard only)

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- fetch_req  in  1  fetch read request, held until granted
- fetch_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored (forced 00)
- fetch_flush  in  1  cancel in-flight fetch data; blocks fetch grant this cycle
- fetch_gnt  out  1  combinational; request accepted at next rising edge
- fetch_rvalid  out  1  one-cycle pulse, fetch_rdata valid
- fetch_rdata  out  DATA_W  returned instruction word
- data_req  in  1  load/store request, held until granted
- data_we  in  1  1 = store, 0 = load
- data_addr  in  ADDR_W  data byte address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  combinational accept
- data_rvalid  out  1  one-cycle pulse: load data or error response
- data_rdata  out  DATA_W  load data (0 on error)
- data_err  out  1  valid with data_rvalid; misaligned access
- mem_addr  out  ADDR_W  registered memory address
- mem_we  out  1  registered memory write enable
- mem_wdata  out  DATA_W  registered memory write data
- mem_rdata  in  DATA_W  memory read word, updated by memory on falling edge

## Operation
- Transfer: a requester's access is accepted at a rising edge where req and gnt were both high.
- Both gnt are 0 while rst_n is low.
- Arbitration: data has priority over fetch. fetch_gnt = fetch_req & ~fetch_flush & ~data_req, unless the starvation guard overrides.
- At most one gnt is high per cycle.
- Accepted fetch: mem_addr = {fetch_addr[9:2],2'b00}, mem_we = 0.
- Accepted data with data_addr[1:0]==00: mem_addr = data_addr, mem_we = data_we, mem_wdata = data_wdata.
- Accepted data with data_addr[1:0]!=00: the access is rejected.
  - mem_we stays 0 and no memory access occurs.
  - The response is data_rvalid=1, data_err=1, data_rdata=0.
  - Rejecting misaligned addresses also excludes addresses above 1020, whose byte+3 would leave the array.
- Stores complete silently: no rvalid.
- Internal pipeline: one return stage holding {valid, owner, is_read, err}.
- mem_addr holds its last value when idle. mem_we is 0 in any cycle with no accepted store.

## Timing
- Accept at edge E: the mem_* outputs carry the access during cycle E→E+1. The memory latches or writes on the falling edge inside that cycle.
- Read return: mem_rdata is captured at edge E+1. rvalid is high and rdata is valid for exactly the cycle E+1→E+2, so load-to-use latency is 2 edges.
- Throughput: one access per cycle; back-to-back accepts are allowed on consecutive edges.
- Error response: same timing as a read (edge E+1).
- fetch_flush high at edge E+1 suppresses fetch_rvalid for a fetch accepted at E. fetch_rdata may still update.
- fetch_flush does not affect data traffic.
- Simultaneous requests: data wins, and fetch stays pending with gnt low.
- Reset at any edge with rst_n low:
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Both rvalid=0, both rdata=0, data_err=0.
  - The return stage is cleared, so an in-flight read produces no rvalid.
  - The streak counter is cleared.
  - No write occurs on the falling edge following a reset edge.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A streak counter (width clog2(MAX_DATA_STREAK+1)) counts data accepts at edges where fetch_req was high.
  - The counter clears at any edge where fetch_req is low or a fetch is accepted.
  - When count==MAX_DATA_STREAK and fetch_req & ~fetch_flush: fetch_gnt=1 and data_gnt=0 for that cycle.
- Undefined: strict data priority, no counter; fetch can starve indefinitely.

## Test plan
- Reset with fetch_req=1 and data_req=1 held, rst_n=0 for 3 edges: all gnt/rvalid/mem_we stay 0 throughout. After release, the first accept is data.
- Store 0xDEADBEEF to 0x010, then load 0x010 on the next edge: mem_we high for one cycle only. The load gets data_rvalid with data_rdata=0xDEADBEEF 2 edges after its accept.
- Back-to-back fetches at 0x000, 0x004, 0x008 on consecutive edges: three consecutive fetch_rvalid cycles carrying the preloaded words in order. fetch_addr=0x006 fetches 0x004.
- Load at 0x013: data_rvalid=1, data_err=1, data_rdata=0, mem_we never asserted, memory unchanged.
- Fetch accepted at edge E with fetch_flush=1 at E+1: no fetch_rvalid. A subsequent fetch returns normally.
- Guard on, MAX_DATA_STREAK=4, data_req and fetch_req held high: grants follow D,D,D,D,F,D,D,D,D,F. With the guard off, all grants are D.
